// File: rtl/rq_cfg_route_stage.sv
// Registered RQ stage ahead of the Type 1 -> Type 0 converter: classifies config
// requests by bus number, tags every beat with a route code and drops out-of-range ones.
module rq_cfg_route_stage #(
  parameter int IF_WIDTH       = 512,
  parameter int TKEEP_WIDTH    = 16,
  parameter int RQ_TUSER_WIDTH = 183
) (
  input  logic                      user_clk,
  input  logic                      user_reset,
  input  logic [7:0]                sec_bus,
  input  logic [7:0]                sub_bus,
  input  logic [IF_WIDTH-1:0]       s_axis_rq_tdata,
  input  logic [TKEEP_WIDTH-1:0]    s_axis_rq_tkeep,
  input  logic                      s_axis_rq_tlast,
  input  logic [RQ_TUSER_WIDTH-1:0] s_axis_rq_tuser,
  input  logic                      s_axis_rq_tvalid,
  output logic                      s_axis_rq_tready,
  output logic [IF_WIDTH-1:0]       m_axis_rq_tdata,
  output logic [TKEEP_WIDTH-1:0]    m_axis_rq_tkeep,
  output logic                      m_axis_rq_tlast,
  output logic [RQ_TUSER_WIDTH-1:0] m_axis_rq_tuser,
  output logic                      m_axis_rq_tvalid,
  input  logic                      m_axis_rq_tready,
  output logic [1:0]                select,
  output logic                      drop_pulse,
  output logic [15:0]               drop_count
);

  localparam int BW = 2 + RQ_TUSER_WIDTH + 1 + TKEEP_WIDTH + IF_WIDTH;

  typedef enum logic [1:0] {
    ST_SOP  = 2'b00,
    ST_PASS = 2'b01,
    ST_DROP = 2'b10
  } state_e;

  // Unsigned compare; with sub < sec the forward window is empty, so only bus == sec survives.
  function automatic logic [1:0] route_code(input logic [3:0] req_type, input logic [7:0] bus,
                                            input logic [7:0] sec, input logic [7:0] sub);
    logic [1:0] code;
    if (!((req_type == 4'b1010) || (req_type == 4'b1011))) begin
      code = 2'b00;
    end else if (bus == sec) begin
      code = 2'b01;
    end else if ((bus > sec) && (bus <= sub)) begin
      code = 2'b10;
    end else begin
      code = 2'b11;
    end
    return code;
  endfunction

  state_e          state_q, state_d;
  logic [1:0]      code_q, code_d;
  logic            tready_q, tready_d;
  logic            out_valid_q, out_valid_d;
  logic [BW-1:0]   out_beat_q, out_beat_d;
  logic            skid_valid_q, skid_valid_d;
  logic [BW-1:0]   skid_beat_q, skid_beat_d;
  logic            drop_pulse_q, drop_pulse_d;
  logic [15:0]     drop_count_q, drop_count_d;

  logic            accept;
  logic            enq;
  logic            drop_sop;
  logic [1:0]      sop_code;
  logic [1:0]      beat_sel;
  logic            out_free;
  logic [BW-1:0]   in_beat;

  // Packet FSM: classify on SOP, then pass or swallow the remaining beats.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    enq      = 1'b0;
    drop_sop = 1'b0;
    beat_sel = code_q;
    accept   = s_axis_rq_tvalid && tready_q;
    sop_code = route_code(s_axis_rq_tdata[78:75], s_axis_rq_tdata[119:112], sec_bus, sub_bus);
    case (state_q)
      ST_SOP: begin
        beat_sel = sop_code;
        if (accept) begin
          if (sop_code == 2'b11) begin
            drop_sop = 1'b1;
            state_d  = s_axis_rq_tlast ? ST_SOP : ST_DROP;
          end else begin
            enq     = 1'b1;
            code_d  = sop_code;
            state_d = s_axis_rq_tlast ? ST_SOP : ST_PASS;
          end
        end else begin
          state_d = ST_SOP;
        end
      end
      ST_PASS: begin
        if (accept) begin
          enq     = 1'b1;
          state_d = s_axis_rq_tlast ? ST_SOP : ST_PASS;
        end else begin
          state_d = ST_PASS;
        end
      end
      ST_DROP: begin
        if (accept && s_axis_rq_tlast) begin
          state_d = ST_SOP;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_SOP;
      end
    endcase
  end

  assign in_beat = {beat_sel, s_axis_rq_tuser, s_axis_rq_tlast, s_axis_rq_tkeep, s_axis_rq_tdata};

  // Two-slot skid buffer; the skid slot only fills while the output register is stalled.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_beat_d   = out_beat_q;
    skid_valid_d = skid_valid_q;
    skid_beat_d  = skid_beat_q;
    out_free     = m_axis_rq_tready || !out_valid_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d = 1'b1;
        out_beat_d  = skid_beat_q;
        if (enq) begin
          skid_beat_d = in_beat;
        end else begin
          skid_valid_d = 1'b0;
        end
      end else if (enq) begin
        out_valid_d = 1'b1;
        out_beat_d  = in_beat;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      if (enq) begin
        skid_valid_d = 1'b1;
        skid_beat_d  = in_beat;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
    tready_d = !skid_valid_d;
  end

  // Drop reporting: one pulse per dropped packet, saturating counter.
  always_comb begin
    drop_pulse_d = drop_sop;
    if (drop_sop && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end else begin
      drop_count_d = drop_count_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state_q      <= ST_SOP;
      code_q       <= 2'b00;
      tready_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_beat_q   <= {BW{1'b0}};
      skid_valid_q <= 1'b0;
      skid_beat_q  <= {BW{1'b0}};
      drop_pulse_q <= 1'b0;
      drop_count_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      tready_q     <= tready_d;
      out_valid_q  <= out_valid_d;
      out_beat_q   <= out_beat_d;
      skid_valid_q <= skid_valid_d;
      skid_beat_q  <= skid_beat_d;
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign s_axis_rq_tready = tready_q;
  assign m_axis_rq_tvalid = out_valid_q;
  assign {select, m_axis_rq_tuser, m_axis_rq_tlast, m_axis_rq_tkeep, m_axis_rq_tdata} = out_beat_q;
  assign drop_pulse       = drop_pulse_q;
  assign drop_count       = drop_count_q;

endmodule

// File: tb/tb_rq_cfg_route_stage.sv
// Directed bench for rq_cfg_route_stage: route codes, drops, stalls, reset and counter saturation.
module tb_rq_cfg_route_stage;

  logic         user_clk = 1'b0;
  logic         user_reset;
  logic [7:0]   sec_bus, sub_bus;
  logic [511:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic         s_tlast;
  logic [182:0] s_tuser;
  logic         s_tvalid;
  logic         s_tready;
  logic [511:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic         m_tlast;
  logic [182:0] m_tuser;
  logic         m_tvalid;
  logic         m_tready;
  logic [1:0]   select;
  logic         drop_pulse;
  logic [15:0]  drop_count;

  rq_cfg_route_stage #(.IF_WIDTH(512), .TKEEP_WIDTH(16), .RQ_TUSER_WIDTH(183)) dut (
    .user_clk(user_clk), .user_reset(user_reset), .sec_bus(sec_bus), .sub_bus(sub_bus),
    .s_axis_rq_tdata(s_tdata), .s_axis_rq_tkeep(s_tkeep), .s_axis_rq_tlast(s_tlast),
    .s_axis_rq_tuser(s_tuser), .s_axis_rq_tvalid(s_tvalid), .s_axis_rq_tready(s_tready),
    .m_axis_rq_tdata(m_tdata), .m_axis_rq_tkeep(m_tkeep), .m_axis_rq_tlast(m_tlast),
    .m_axis_rq_tuser(m_tuser), .m_axis_rq_tvalid(m_tvalid), .m_axis_rq_tready(m_tready),
    .select(select), .drop_pulse(drop_pulse), .drop_count(drop_count)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    logic [511:0] d;
    logic [15:0]  k;
    logic         l;
    logic [182:0] u;
    logic [1:0]   s;
  } beat_t;

  typedef struct {
    logic [3:0] rt;
    logic [7:0] bus;
    logic [1:0] sel;
  } vec_t;

  beat_t        exp_q[$];
  int           checks = 0;
  int           failures = 0;
  int           n_out = 0;
  int           rdy_mode = 1;
  int           exp_drops = 0;

  task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pat(input logic [31:0] id);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = id * 32'h0100_0193 + 32'(i);
    return d;
  endfunction

  function automatic logic [511:0] desc(input logic [3:0] rt, input logic [7:0] bus, input logic [31:0] id);
    logic [511:0] d;
    d = pat(id);
    d[78:75]   = rt;
    d[119:112] = bus;
    return d;
  endfunction

  function automatic logic [182:0] mk_user(input logic [31:0] id);
    return {id[22:0], {5{id ^ 32'h5A5A_0F0F}}};
  endfunction

  // Downstream ready driver.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge user_clk);
      #1;
      case (rdy_mode)
        0:       m_tready = 1'b0;
        1:       m_tready = 1'b1;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output scoreboard and stall-stability monitor.
  logic         stall_q = 1'b0;
  logic [511:0] snap_d;
  logic [1:0]   snap_s;
  always @(negedge user_clk) begin
    beat_t e;
    if (user_reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check_val("stall_valid", 512'(m_tvalid), 512'(1));
        check_val("stall_data", m_tdata, snap_d);
        check_val("stall_select", 512'(select), 512'(snap_s));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_beat", 512'(m_tdata), 512'(0));
        end else begin
          e = exp_q.pop_front();
          check_val("out_data", m_tdata, e.d);
          check_val("out_keep", 512'(m_tkeep), 512'(e.k));
          check_val("out_last", 512'(m_tlast), 512'(e.l));
          check_val("out_user", 512'(m_tuser), 512'(e.u));
          check_val("out_select", 512'(select), 512'(e.s));
          n_out++;
        end
      end
      stall_q = m_tvalid && !m_tready;
      snap_d  = m_tdata;
      snap_s  = select;
    end
  end

  task automatic send(input logic [511:0] d, input logic [15:0] k, input logic l, input logic [182:0] u,
                      input logic push, input logic [1:0] sel, output int waited);
    beat_t e;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    waited = 0;
    if (push) begin
      e.d = d; e.k = k; e.l = l; e.u = u; e.s = sel;
      exp_q.push_back(e);
    end
    forever begin
      @(negedge user_clk);
      if (s_tready) break;
      waited++;
      if (waited > 300) begin
        check_val("accept_timeout", 512'(0), 512'(1));
        break;
      end
    end
    @(posedge user_clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [3:0] rt, input logic [7:0] bus, input int nbeats, input logic push,
                          input logic [1:0] sel, input logic [31:0] id, output int max_wait);
    int w;
    max_wait = 0;
    for (int i = 0; i < nbeats; i++) begin
      logic [511:0] d;
      d = (i == 0) ? desc(rt, bus, id) : pat(id + 32'(i));
      send(d, (i == nbeats - 1) ? 16'h00FF : 16'hFFFF, (i == nbeats - 1), mk_user(id + 32'(i)), push, sel, w);
      if (w > max_wait) max_wait = w;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge user_clk);
      n++;
    end
    @(posedge user_clk);
    #1;
    check_val("drain", 512'(exp_q.size()), 512'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    w;
    int    n0;
    vec_t  vt[8];

    user_reset = 1'b1; sec_bus = 8'h02; sub_bus = 8'h05;
    s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = '0; s_tvalid = 1'b0;
    #2;
    check_val("rst_m_tvalid", 512'(m_tvalid), 512'(0));
    check_val("rst_s_tready", 512'(s_tready), 512'(0));
    check_val("rst_select", 512'(select), 512'(0));
    check_val("rst_drop_pulse", 512'(drop_pulse), 512'(0));
    check_val("rst_drop_count", 512'(drop_count), 512'(0));
    repeat (2) @(posedge user_clk);
    @(negedge user_clk);
    user_reset = 1'b0;
    @(posedge user_clk);
    #1;
    check_val("tready_after_rst", 512'(s_tready), 512'(1));

    // Single-beat Type 1 read to the secondary bus, 1-cycle latency.
    send(desc(4'b1010, 8'h02, 32'h100), 16'hFFFF, 1'b1, mk_user(32'h100), 1'b1, 2'b01, w);
    check_val("t1_wait", 512'(w), 512'(0));
    check_val("t1_latency_valid", 512'(m_tvalid), 512'(1));
    check_val("t1_latency_select", 512'(select), 512'(2'b01));
    drain();

    // 3-beat forward, then a memory write; no stalls at the input.
    n0 = n_out;
    send_pkt(4'b1011, 8'h04, 3, 1'b1, 2'b10, 32'h200, w);
    check_val("t2_wait", 512'(w), 512'(0));
    send_pkt(4'b0001, 8'h04, 2, 1'b1, 2'b00, 32'h300, w);
    check_val("t2_mem_wait", 512'(w), 512'(0));
    drain();
    check_val("t2_count", 512'(n_out - n0), 512'(5));

    // 4-beat out-of-range Type 1 is swallowed.
    n0 = n_out;
    send(desc(4'b1011, 8'h09, 32'h400), 16'hFFFF, 1'b0, mk_user(32'h400), 1'b0, 2'b11, w);
    exp_drops++;
    check_val("t3_pulse_on", 512'(drop_pulse), 512'(1));
    check_val("t3_no_valid", 512'(m_tvalid), 512'(0));
    for (int i = 1; i < 4; i++) begin
      send(pat(32'h400 + 32'(i)), 16'hFFFF, (i == 3), mk_user(32'h401), 1'b0, 2'b11, w);
      check_val("t3_tready", 512'(w), 512'(0));
      check_val("t3_pulse_off", 512'(drop_pulse), 512'(0));
      check_val("t3_no_valid", 512'(m_tvalid), 512'(0));
    end
    check_val("t3_drop_count", 512'(drop_count), 512'(1));
    send_pkt(4'b0000, 8'h09, 2, 1'b1, 2'b00, 32'h500, w);
    drain();
    check_val("t3_follow_count", 512'(n_out - n0), 512'(2));

    // Single-beat boundary cases, including sub_bus < sec_bus.
    vt[0] = '{4'b1010, 8'h05, 2'b10};
    vt[1] = '{4'b1010, 8'h06, 2'b11};
    vt[2] = '{4'b1010, 8'h01, 2'b11};
    vt[3] = '{4'b1011, 8'h02, 2'b01};
    vt[4] = '{4'b0000, 8'h09, 2'b00};
    vt[5] = '{4'b1010, 8'h08, 2'b01};
    vt[6] = '{4'b1010, 8'h05, 2'b11};
    vt[7] = '{4'b1011, 8'h09, 2'b11};
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        sec_bus = 8'h08; sub_bus = 8'h03;
      end
      send(desc(vt[i].rt, vt[i].bus, 32'h600 + 32'(i)), 16'hFFFF, 1'b1, mk_user(32'h600 + 32'(i)),
           (vt[i].sel != 2'b11), vt[i].sel, w);
      check_val("t4_pulse", 512'(drop_pulse), 512'(vt[i].sel == 2'b11));
      if (vt[i].sel == 2'b11) exp_drops++;
    end
    drain();
    check_val("t4_drop_count", 512'(drop_count), 512'(exp_drops));
    sec_bus = 8'h02; sub_bus = 8'h05;

    // Back-to-back 8-beat packets under random backpressure.
    n0 = n_out;
    rdy_mode = 2;
    send_pkt(4'b1010, 8'h04, 8, 1'b1, 2'b10, 32'h700, w);
    send_pkt(4'b1011, 8'h02, 8, 1'b1, 2'b01, 32'h800, w);
    send_pkt(4'b0001, 8'h02, 8, 1'b1, 2'b00, 32'h900, w);
    rdy_mode = 1; m_tready = 1'b1;
    drain();
    check_val("t5_count", 512'(n_out - n0), 512'(24));

    // Reset during beat 2 of a 5-beat packet.
    rdy_mode = 0; m_tready = 1'b0;
    send(desc(4'b1010, 8'h04, 32'hA00), 16'hFFFF, 1'b0, mk_user(32'hA00), 1'b1, 2'b10, w);
    send(pat(32'hA01), 16'hFFFF, 1'b0, mk_user(32'hA01), 1'b1, 2'b10, w);
    s_tdata = pat(32'hA02); s_tvalid = 1'b1;
    user_reset = 1'b1;
    #1;
    exp_q.delete();
    exp_drops = 0;
    check_val("t6_valid", 512'(m_tvalid), 512'(0));
    check_val("t6_select", 512'(select), 512'(0));
    check_val("t6_drop_count", 512'(drop_count), 512'(0));
    check_val("t6_tready", 512'(s_tready), 512'(0));
    s_tvalid = 1'b0;
    repeat (2) @(posedge user_clk);
    @(negedge user_clk);
    user_reset = 1'b0;
    rdy_mode = 1; m_tready = 1'b1;
    n0 = n_out;
    send_pkt(4'b1010, 8'h02, 2, 1'b1, 2'b01, 32'hB00, w);
    drain();
    check_val("t6_next_count", 512'(n_out - n0), 512'(2));
    check_val("t6_tvalid_idle", 512'(m_tvalid), 512'(0));

    // Saturation: 65535 single-beat drops back to back, then one more.
    s_tdata = desc(4'b1010, 8'h09, 32'hC00); s_tkeep = 16'hFFFF; s_tlast = 1'b1;
    s_tuser = mk_user(32'hC00); s_tvalid = 1'b1;
    repeat (65535) @(posedge user_clk);
    #1;
    s_tvalid = 1'b0;
    check_val("t7_count_full", 512'(drop_count), 512'(16'hFFFF));
    @(posedge user_clk);
    #1;
    check_val("t7_pulse_idle", 512'(drop_pulse), 512'(0));
    send(desc(4'b1011, 8'h00, 32'hD00), 16'hFFFF, 1'b1, mk_user(32'hD00), 1'b0, 2'b11, w);
    check_val("t7_pulse_sat", 512'(drop_pulse), 512'(1));
    check_val("t7_count_sat", 512'(drop_count), 512'(16'hFFFF));
    check_val("t7_no_out", 512'(n_out - n0), 512'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
